// File: rtl/fabric_rr_arbiter_if.sv
// Fabric request/response bundle carrying N packed lanes.
// Upstream side of the arbiter uses N = master count; downstream side uses N = 1
// with the widened id.
interface fabric_rr_arbiter_if #(
    parameter int N      = 1,
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32,
    parameter int ID_W   = 4,
    parameter int OP_W   = 8,
    parameter int SIZE_W = 3,
    parameter int ATTR_W = 8,
    parameter int CODE_W = 8
);
    logic [N-1:0]            req_valid;
    logic [N-1:0]            req_ready;
    logic [N*OP_W-1:0]       req_op;
    logic [N*ADDR_W-1:0]     req_addr;
    logic [N*DATA_W-1:0]     req_wdata;
    logic [N*(DATA_W/8)-1:0] req_wstrb;
    logic [N*SIZE_W-1:0]     req_size;
    logic [N*ATTR_W-1:0]     req_attr;
    logic [N*ID_W-1:0]       req_id;

    logic [N-1:0]            rsp_valid;
    logic [N-1:0]            rsp_ready;
    logic [N*DATA_W-1:0]     rsp_rdata;
    logic [N*CODE_W-1:0]     rsp_code;
    logic [N*ID_W-1:0]       rsp_id;

    // Requester side: issues requests, consumes responses.
    modport master (
        output req_valid, req_op, req_addr, req_wdata, req_wstrb, req_size, req_attr, req_id,
        input  req_ready,
        input  rsp_valid, rsp_rdata, rsp_code, rsp_id,
        output rsp_ready
    );

    // Target side: accepts requests, produces responses.
    modport slave (
        input  req_valid, req_op, req_addr, req_wdata, req_wstrb, req_size, req_attr, req_id,
        output req_ready,
        output rsp_valid, rsp_rdata, rsp_code, rsp_id,
        input  rsp_ready
    );
endinterface

// File: rtl/fabric_rr_arbiter.sv
// N-to-1 round-robin fabric arbiter. Master index is prepended to the request id
// so responses can be routed back; each master has a cap on in-flight requests.
module fabric_rr_arbiter #(
    parameter int N_MASTERS = 4,
    parameter int ADDR_W    = 32,
    parameter int DATA_W    = 32,
    parameter int ID_W      = 4,
    parameter int OP_W      = 8,
    parameter int SIZE_W    = 3,
    parameter int ATTR_W    = 8,
    parameter int CODE_W    = 8,
    parameter int MAX_OUTST = 4
) (
    input  logic                clk,
    input  logic                rst_n,
    fabric_rr_arbiter_if.slave  m,
    fabric_rr_arbiter_if.master ds,
    output logic                err_bad_rsp
);
    localparam int IDX_W  = $clog2(N_MASTERS);
    localparam int DID_W  = ID_W + IDX_W;
    localparam int CNT_W  = $clog2(MAX_OUTST + 1);
    localparam int STRB_W = DATA_W / 8;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MAX_OUTST);
    localparam logic [IDX_W:0]   N_EXT   = (IDX_W+1)'(N_MASTERS);

    logic [IDX_W-1:0] ptr_q, ptr_d;
    logic [IDX_W-1:0] grant_q, grant_d;
    logic             locked_q, locked_d;
    logic [CNT_W-1:0] cnt_q [N_MASTERS];
    logic [CNT_W-1:0] cnt_d [N_MASTERS];
    logic             err_q, err_d;

    logic [N_MASTERS-1:0] elig;
    logic [IDX_W-1:0]     sel;
    logic                 any_elig;
    logic                 ds_valid;
    logic                 req_fire;
    logic [ID_W-1:0]      sel_id;
    logic [IDX_W-1:0]     rsp_idx;
    logic                 rsp_routable;
    logic                 rsp_ready;
    logic                 rsp_fire;

    // Round-robin pick starting just after ptr; a locked grant overrides the scan
    // so a stalled downstream request stays stable.
    always_comb begin
        logic [IDX_W:0] cand;
        cand     = '0;
        sel      = grant_q;
        any_elig = 1'b0;
        for (int i = 0; i < N_MASTERS; i++) begin
            elig[i] = m.req_valid[i] && (cnt_q[i] < CNT_MAX);
        end
        if (!locked_q) begin
            sel = '0;
            // Scan from farthest to nearest so the nearest eligible index wins.
            for (int k = N_MASTERS; k >= 1; k--) begin
                cand = {1'b0, ptr_q} + (IDX_W+1)'(k);
                if (cand >= N_EXT) begin
                    cand = cand - N_EXT;
                end
                for (int i = 0; i < N_MASTERS; i++) begin
                    if (cand[IDX_W-1:0] == IDX_W'(i) && elig[i]) begin
                        sel      = IDX_W'(i);
                        any_elig = 1'b1;
                    end
                end
            end
        end
    end

    // Steer the selected master onto the downstream request and return its ready.
    always_comb begin
        ds_valid     = 1'b0;
        sel_id       = '0;
        ds.req_op    = '0;
        ds.req_addr  = '0;
        ds.req_wdata = '0;
        ds.req_wstrb = '0;
        ds.req_size  = '0;
        ds.req_attr  = '0;
        for (int i = 0; i < N_MASTERS; i++) begin
            if (sel == IDX_W'(i)) begin
                ds_valid     = locked_q ? m.req_valid[i] : any_elig;
                sel_id       = m.req_id[i*ID_W +: ID_W];
                ds.req_op    = m.req_op[i*OP_W +: OP_W];
                ds.req_addr  = m.req_addr[i*ADDR_W +: ADDR_W];
                ds.req_wdata = m.req_wdata[i*DATA_W +: DATA_W];
                ds.req_wstrb = m.req_wstrb[i*STRB_W +: STRB_W];
                ds.req_size  = m.req_size[i*SIZE_W +: SIZE_W];
                ds.req_attr  = m.req_attr[i*ATTR_W +: ATTR_W];
            end
        end
        ds_valid     = ds_valid && rst_n;
        ds.req_valid = ds_valid;
        ds.req_id    = {sel, sel_id};
        req_fire     = ds_valid && ds.req_ready;
        for (int i = 0; i < N_MASTERS; i++) begin
            m.req_ready[i] = req_fire && (sel == IDX_W'(i));
        end
    end

    // Route the downstream response by its id prefix; unroutable ones are sunk.
    always_comb begin
        rsp_idx      = ds.rsp_id[DID_W-1:ID_W];
        rsp_routable = {1'b0, rsp_idx} < N_EXT;
        rsp_ready    = !rsp_routable;
        for (int i = 0; i < N_MASTERS; i++) begin
            m.rsp_valid[i] = rst_n && ds.rsp_valid && rsp_routable && (rsp_idx == IDX_W'(i));
            if (rsp_routable && rsp_idx == IDX_W'(i)) begin
                rsp_ready = m.rsp_ready[i];
            end
        end
        rsp_ready    = rsp_ready && rst_n;
        ds.rsp_ready = rsp_ready;
        rsp_fire     = ds.rsp_valid && rsp_ready;
    end

    assign m.rsp_rdata  = {N_MASTERS{ds.rsp_rdata}};
    assign m.rsp_code   = {N_MASTERS{ds.rsp_code}};
    assign m.rsp_id     = {N_MASTERS{ds.rsp_id[ID_W-1:0]}};
    assign err_bad_rsp  = err_q;

    // Next-state for pointer, lock, per-master in-flight counters and error flag.
    always_comb begin
        logic inc, dec;
        inc      = 1'b0;
        dec      = 1'b0;
        ptr_d    = ptr_q;
        grant_d  = grant_q;
        locked_d = locked_q;
        err_d    = rsp_fire && !rsp_routable;
        for (int i = 0; i < N_MASTERS; i++) begin
            inc      = req_fire && (sel == IDX_W'(i));
            dec      = rsp_fire && rsp_routable && (rsp_idx == IDX_W'(i));
            cnt_d[i] = cnt_q[i];
            if (dec && cnt_q[i] == '0) begin
                err_d = 1'b1;
            end
            if (inc && !dec && cnt_q[i] != CNT_MAX) begin
                cnt_d[i] = cnt_q[i] + 1'b1;
            end else if (dec && !inc && cnt_q[i] != '0) begin
                cnt_d[i] = cnt_q[i] - 1'b1;
            end
        end
        if (req_fire) begin
            ptr_d    = sel;
            locked_d = 1'b0;
        end else if (ds_valid) begin
            locked_d = 1'b1;
            grant_d  = sel;
        end
    end

    // State registers; reset leaves ptr at N-1 so master 0 wins first.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr_q    <= IDX_W'(N_MASTERS - 1);
            grant_q  <= '0;
            locked_q <= 1'b0;
            err_q    <= 1'b0;
            for (int i = 0; i < N_MASTERS; i++) begin
                cnt_q[i] <= '0;
            end
        end else begin
            ptr_q    <= ptr_d;
            grant_q  <= grant_d;
            locked_q <= locked_d;
            err_q    <= err_d;
            for (int i = 0; i < N_MASTERS; i++) begin
                cnt_q[i] <= cnt_d[i];
            end
        end
    end
endmodule

// File: tb/tb_fabric_rr_arbiter.sv
// Self-checking bench for fabric_rr_arbiter: a 4-master instance for most scenarios
// and a 3-master instance to reach an unroutable response prefix.
module tb_fabric_rr_arbiter;
    localparam int N     = 4;
    localparam int ID_W  = 4;
    localparam int DID_W = 6;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic err_bad_rsp;
    logic err3;
    int   total = 0;
    int   passed = 0;

    logic [DID_W-1:0] req_sb [$];
    logic [ID_W-1:0]  rsp_sb [$];

    fabric_rr_arbiter_if #(.N(4), .ID_W(ID_W))  u_up ();
    fabric_rr_arbiter_if #(.N(1), .ID_W(DID_W)) u_dn ();
    fabric_rr_arbiter_if #(.N(3), .ID_W(ID_W))  u_up3 ();
    fabric_rr_arbiter_if #(.N(1), .ID_W(DID_W)) u_dn3 ();

    fabric_rr_arbiter #(.N_MASTERS(4), .ID_W(ID_W), .MAX_OUTST(4)) dut (
        .clk(clk), .rst_n(rst_n), .m(u_up), .ds(u_dn), .err_bad_rsp(err_bad_rsp)
    );

    fabric_rr_arbiter #(.N_MASTERS(3), .ID_W(ID_W), .MAX_OUTST(4)) dut3 (
        .clk(clk), .rst_n(rst_n), .m(u_up3), .ds(u_dn3), .err_bad_rsp(err3)
    );

    always #5 clk = ~clk;

    function automatic logic [ID_W-1:0] id_of(input int i);
        return ID_W'(i + 5);
    endfunction

    function automatic logic [31:0] addr_of(input int i);
        return 32'h1000_0000 + 32'(i * 256);
    endfunction

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        u_up.req_valid  = '0;
        u_up.rsp_ready  = '0;
        u_dn.req_ready  = 1'b0;
        u_dn.rsp_valid  = 1'b0;
        u_dn.rsp_rdata  = '0;
        u_dn.rsp_code   = '0;
        u_dn.rsp_id     = '0;
        u_up3.req_valid = '0;
        u_up3.rsp_ready = '0;
        u_dn3.req_ready = 1'b0;
        u_dn3.rsp_valid = 1'b0;
        u_dn3.rsp_rdata = '0;
        u_dn3.rsp_code  = '0;
        u_dn3.rsp_id    = '0;
    endtask

    task automatic init_fields();
        for (int i = 0; i < N; i++) begin
            u_up.req_op[i*8 +: 8]     = 8'(i + 1);
            u_up.req_addr[i*32 +: 32] = addr_of(i);
            u_up.req_wdata[i*32 +: 32] = 32'hD000_0000 + 32'(i);
            u_up.req_wstrb[i*4 +: 4]  = 4'hF;
            u_up.req_size[i*3 +: 3]   = 3'd2;
            u_up.req_attr[i*8 +: 8]   = 8'(i);
            u_up.req_id[i*4 +: 4]     = id_of(i);
        end
        u_up3.req_op    = '0;
        u_up3.req_addr  = '0;
        u_up3.req_wdata = '0;
        u_up3.req_wstrb = '0;
        u_up3.req_size  = '0;
        u_up3.req_attr  = '0;
        u_up3.req_id    = '0;
    endtask

    task automatic do_reset();
        clear_inputs();
        rst_n = 1'b0;
        cyc();
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        u_up.req_valid = 4'b1111;
        u_dn.req_ready = 1'b1;
        u_up.rsp_ready = 4'b1111;
        u_dn.rsp_valid = 1'b1;
        u_dn.rsp_id    = {2'd0, 4'h3};
        #2;
        total++;
        if ({u_dn.req_valid, u_up.req_ready, u_up.rsp_valid, u_dn.rsp_ready, err_bad_rsp} !== 11'b0)
            $display("FAIL reset_outputs: got %b want 0", {u_dn.req_valid, u_up.req_ready, u_up.rsp_valid, u_dn.rsp_ready, err_bad_rsp});
        else passed++;
        cyc();
        total++;
        if ({u_dn.req_valid, u_up.req_ready, err_bad_rsp} !== 6'b0)
            $display("FAIL reset_hold: got %b want 0", {u_dn.req_valid, u_up.req_ready, err_bad_rsp});
        else passed++;
        clear_inputs();
        rst_n = 1'b1;
    endtask

    task automatic test_rr_order();
        int seq [5] = '{0, 1, 2, 3, 0};
        do_reset();
        foreach (seq[k]) req_sb.push_back({2'(seq[k]), id_of(seq[k])});
        u_up.req_valid = 4'b1111;
        u_dn.req_ready = 1'b1;
        for (int k = 0; k < 5; k++) begin
            logic [DID_W-1:0] exp_id;
            #2;
            exp_id = req_sb.pop_front();
            total++;
            if (!(u_dn.req_valid && u_dn.req_ready) || u_dn.req_id !== exp_id ||
                u_up.req_ready !== (4'b0001 << exp_id[5:4]) || u_dn.req_addr !== addr_of(int'(exp_id[5:4])))
                $display("FAIL rr_grant%0d: got id %h ready %b addr %h want id %h", k, u_dn.req_id, u_up.req_ready, u_dn.req_addr, exp_id);
            else passed++;
            cyc();
        end
        clear_inputs();
    endtask

    task automatic test_lock_hold();
        do_reset();
        req_sb.push_back({2'd1, id_of(1)});
        req_sb.push_back({2'd0, id_of(0)});
        u_up.req_valid = 4'b0010;
        for (int c = 0; c < 5; c++) begin
            if (c >= 1) u_up.req_valid[0] = 1'b1;
            #2;
            total++;
            if (u_dn.req_valid !== 1'b1 || u_dn.req_id !== {2'd1, id_of(1)} ||
                u_dn.req_addr !== addr_of(1) || u_up.req_ready !== 4'b0)
                $display("FAIL lock_stable%0d: got v %b id %h addr %h want v 1 id %h", c, u_dn.req_valid, u_dn.req_id, u_dn.req_addr, {2'd1, id_of(1)});
            else passed++;
            cyc();
        end
        u_dn.req_ready = 1'b1;
        for (int k = 0; k < 2; k++) begin
            logic [DID_W-1:0] exp_id;
            #2;
            exp_id = req_sb.pop_front();
            total++;
            if (!(u_dn.req_valid && u_dn.req_ready) || u_dn.req_id !== exp_id)
                $display("FAIL lock_release%0d: got id %h want %h", k, u_dn.req_id, exp_id);
            else passed++;
            cyc();
            u_up.req_valid[1] = 1'b0;
        end
        clear_inputs();
    endtask

    task automatic test_outst_cap();
        logic [ID_W-1:0] exp_rid;
        do_reset();
        u_up.req_valid = 4'b0100;
        u_dn.req_ready = 1'b1;
        for (int k = 0; k < 4; k++) begin
            #2;
            total++;
            if (u_up.req_ready !== 4'b0100)
                $display("FAIL cap_issue%0d: got ready %b want 0100", k, u_up.req_ready);
            else passed++;
            cyc();
        end
        #2;
        total++;
        if (u_up.req_ready !== 4'b0 || u_dn.req_valid !== 1'b0)
            $display("FAIL cap_blocked: got ready %b ds_valid %b want 0000 0", u_up.req_ready, u_dn.req_valid);
        else passed++;
        u_up.req_valid[3] = 1'b1;
        #2;
        total++;
        if (u_up.req_ready !== 4'b1000 || u_dn.req_id !== {2'd3, id_of(3)})
            $display("FAIL cap_other_served: got ready %b id %h want 1000 %h", u_up.req_ready, u_dn.req_id, {2'd3, id_of(3)});
        else passed++;
        cyc();
        u_up.req_valid[3] = 1'b0;
        u_dn.rsp_valid = 1'b1;
        u_dn.rsp_id    = {2'd2, 4'h9};
        u_up.rsp_ready = 4'b0100;
        rsp_sb.push_back(4'h9);
        #2;
        exp_rid = rsp_sb.pop_front();
        total++;
        if (u_up.rsp_valid !== 4'b0100 || u_dn.rsp_ready !== 1'b1 || u_up.rsp_id[8 +: 4] !== exp_rid || u_up.req_ready !== 4'b0)
            $display("FAIL cap_rsp: got v %b rdy %b id %h req_rdy %b want 0100 1 %h 0000", u_up.rsp_valid, u_dn.rsp_ready, u_up.rsp_id[8 +: 4], u_up.req_ready, exp_rid);
        else passed++;
        cyc();
        u_dn.rsp_valid = 1'b0;
        #2;
        total++;
        if (u_up.req_ready !== 4'b0100)
            $display("FAIL cap_reopen: got ready %b want 0100", u_up.req_ready);
        else passed++;
        cyc();
        clear_inputs();
    endtask

    task automatic test_rsp_backpressure();
        logic [ID_W-1:0] exp_rid;
        do_reset();
        u_up.req_valid = 4'b1000;
        u_dn.req_ready = 1'b1;
        cyc();
        cyc();
        clear_inputs();
        u_dn.rsp_valid = 1'b1;
        u_dn.rsp_id    = {2'd3, 4'hA};
        u_dn.rsp_rdata = 32'hCAFE_0003;
        rsp_sb.push_back(4'hA);
        for (int c = 0; c < 3; c++) begin
            #2;
            total++;
            if (u_up.rsp_valid !== 4'b1000 || u_dn.rsp_ready !== 1'b0)
                $display("FAIL rsp_stall%0d: got v %b rdy %b want 1000 0", c, u_up.rsp_valid, u_dn.rsp_ready);
            else passed++;
            cyc();
        end
        u_up.rsp_ready[3] = 1'b1;
        #2;
        exp_rid = rsp_sb.pop_front();
        total++;
        if (u_dn.rsp_ready !== 1'b1 || u_up.rsp_id[12 +: 4] !== exp_rid || u_up.rsp_rdata[96 +: 32] !== 32'hCAFE_0003)
            $display("FAIL rsp_deliver: got rdy %b id %h data %h want 1 %h cafe0003", u_dn.rsp_ready, u_up.rsp_id[12 +: 4], u_up.rsp_rdata[96 +: 32], exp_rid);
        else passed++;
        cyc();
        clear_inputs();
        #2;
        total++;
        if (dut.cnt_q[3] !== 3'd1 || err_bad_rsp !== 1'b0)
            $display("FAIL rsp_cnt_dec: got cnt %0d err %b want 1 0", dut.cnt_q[3], err_bad_rsp);
        else passed++;
        cyc();
    endtask

    task automatic test_bad_rsp();
        do_reset();
        u_dn3.rsp_valid = 1'b1;
        u_dn3.rsp_id    = {2'd3, 4'h1};
        u_up3.rsp_ready = 3'b111;
        u_dn.rsp_valid  = 1'b1;
        u_dn.rsp_id     = {2'd1, 4'h7};
        u_up.rsp_ready  = 4'b0010;
        #2;
        total++;
        if (u_dn3.rsp_ready !== 1'b1 || u_up3.rsp_valid !== 3'b0 || err3 !== 1'b0)
            $display("FAIL bad_rsp_sink: got rdy %b v %b err %b want 1 000 0", u_dn3.rsp_ready, u_up3.rsp_valid, err3);
        else passed++;
        total++;
        if (u_up.rsp_valid !== 4'b0010 || err_bad_rsp !== 1'b0)
            $display("FAIL unexp_rsp_deliver: got v %b err %b want 0010 0", u_up.rsp_valid, err_bad_rsp);
        else passed++;
        cyc();
        clear_inputs();
        #2;
        total++;
        if (err3 !== 1'b1 || err_bad_rsp !== 1'b1 || dut.cnt_q[1] !== 3'd0)
            $display("FAIL bad_rsp_pulse: got err3 %b err %b cnt1 %0d want 1 1 0", err3, err_bad_rsp, dut.cnt_q[1]);
        else passed++;
        cyc();
        #2;
        total++;
        if (err3 !== 1'b0 || err_bad_rsp !== 1'b0)
            $display("FAIL bad_rsp_one_cycle: got err3 %b err %b want 0 0", err3, err_bad_rsp);
        else passed++;
        cyc();
    endtask

    task automatic test_same_cycle_and_reset();
        do_reset();
        u_up.req_valid = 4'b0001;
        u_dn.req_ready = 1'b1;
        cyc();
        cyc();
        u_dn.rsp_valid = 1'b1;
        u_dn.rsp_id    = {2'd0, 4'h2};
        u_up.rsp_ready = 4'b0001;
        #2;
        total++;
        if (u_up.req_ready !== 4'b0001 || u_dn.rsp_ready !== 1'b1)
            $display("FAIL same_cycle_fires: got req_rdy %b rsp_rdy %b want 0001 1", u_up.req_ready, u_dn.rsp_ready);
        else passed++;
        cyc();
        clear_inputs();
        #2;
        total++;
        if (dut.cnt_q[0] !== 3'd2 || err_bad_rsp !== 1'b0)
            $display("FAIL same_cycle_cnt: got cnt %0d err %b want 2 0", dut.cnt_q[0], err_bad_rsp);
        else passed++;
        u_up.req_valid = 4'b0010;
        cyc();
        total++;
        if (dut.locked_q !== 1'b1 || u_dn.req_id !== {2'd1, id_of(1)})
            $display("FAIL pre_reset_lock: got locked %b id %h want 1 %h", dut.locked_q, u_dn.req_id, {2'd1, id_of(1)});
        else passed++;
        rst_n = 1'b0;
        #1;
        total++;
        if (u_dn.req_valid !== 1'b0 || u_up.req_ready !== 4'b0)
            $display("FAIL reset_mid_lock: got v %b rdy %b want 0 0000", u_dn.req_valid, u_up.req_ready);
        else passed++;
        cyc();
        rst_n = 1'b1;
        u_up.req_valid = 4'b1111;
        u_dn.req_ready = 1'b1;
        #2;
        total++;
        if (dut.ptr_q !== 2'd3 || u_dn.req_id !== {2'd0, id_of(0)} || dut.cnt_q[0] !== 3'd0)
            $display("FAIL post_reset_ptr: got ptr %0d id %h cnt0 %0d want 3 %h 0", dut.ptr_q, u_dn.req_id, dut.cnt_q[0], {2'd0, id_of(0)});
        else passed++;
        cyc();
        clear_inputs();
    endtask

    initial begin
        #50000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        clear_inputs();
        init_fields();
        #1;
        test_reset();
        test_rr_order();
        test_lock_hold();
        test_outst_cap();
        test_rsp_backpressure();
        test_bad_rsp();
        test_same_cycle_and_reset();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
